// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO placed after the UART receiver. Bytes are captured on the
// receiver's Data_Valid pulse and leave through a first-word-fall-through valid/ready port.
// A dropped byte raises a sticky Overflow flag. Almost_Full is a watermark for flow control.
module uart_rx_fifo #(
  parameter int unsigned width    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [width-1:0]         Wr_Data,
  input  logic                     Wr_Valid,
  output logic [width-1:0]         Rd_Data,
  output logic                     Rd_Valid,
  input  logic                     Rd_Ready,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Almost_Full,
  output logic                     Overflow,
  input  logic                     Ovf_Clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [width-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q;
  logic             rd_fire, wr_fire, wr_drop;

  // Handshake decode. A write into a full FIFO still succeeds when a read frees a slot.
  always_comb begin
    rd_fire = Rd_Valid & Rd_Ready;
    wr_fire = Wr_Valid & (~Full | rd_fire);
    wr_drop = Wr_Valid & Full & ~rd_fire;
  end

  // Output decode from registered state. Rd_Data is forced to 0 while empty so reset reads 0.
  always_comb begin
    Rd_Valid    = (count_q != '0);
    Rd_Data     = Rd_Valid ? mem[rd_ptr_q] : '0;
    Count       = count_q;
    Full        = (count_q == CW'(DEPTH));
    Almost_Full = (count_q >= CW'(AF_LEVEL));
    Overflow    = overflow_q;
  end

  // Occupancy next state. A simultaneous read and write leave it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array. Its contents need no reset because Rd_Data is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_q] <= Wr_Data;
    end
  end

  // Pointers, count and sticky overflow. When a drop and a clear land together, set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (rd_fire) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
      count_q <= count_d;
      if (wr_drop) begin
        overflow_q <= 1'b1;
      end else if (Ovf_Clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo. Stimulus pushes expected bytes into a queue. A monitor pops
// and compares on every accepted read. Flag and count checks are directed.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] Wr_Data;
  logic       Wr_Valid;
  logic [7:0] Rd_Data;
  logic       Rd_Valid;
  logic       Rd_Ready;
  logic [4:0] Count;
  logic       Full;
  logic       Almost_Full;
  logic       Overflow;
  logic       Ovf_Clr;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(
    .width   (8),
    .DEPTH   (16),
    .AF_LEVEL(12)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Wr_Data    (Wr_Data),
    .Wr_Valid   (Wr_Valid),
    .Rd_Data    (Rd_Data),
    .Rd_Valid   (Rd_Valid),
    .Rd_Ready   (Rd_Ready),
    .Count      (Count),
    .Full       (Full),
    .Almost_Full(Almost_Full),
    .Overflow   (Overflow),
    .Ovf_Clr    (Ovf_Clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait one clock edge, then move 1 time unit past it so inputs change away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One write strobe. The caller decides whether the byte is expected to be read back.
  task automatic write_byte(input logic [7:0] b, input bit expect_accept);
    Wr_Data  = b;
    Wr_Valid = 1'b1;
    if (expect_accept) exp_q.push_back(b);
    step();
    Wr_Valid = 1'b0;
  endtask

  task automatic drain(input int n);
    Rd_Ready = 1'b1;
    repeat (n) step();
    Rd_Ready = 1'b0;
  endtask

  // Monitor: every accepted read must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && Rd_Valid && Rd_Ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected: got 0x%0h expected none", Rd_Data);
        end else begin
          chk("rd_data", {24'd0, Rd_Data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; Wr_Data = '0; Wr_Valid = 1'b0; Rd_Ready = 1'b0; Ovf_Clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_rd_valid", {31'd0, Rd_Valid}, 0);
    chk("rst_count", {27'd0, Count}, 0);
    chk("rst_full", {31'd0, Full}, 0);
    chk("rst_af", {31'd0, Almost_Full}, 0);
    chk("rst_ovf", {31'd0, Overflow}, 0);
    chk("rst_rd_data", {24'd0, Rd_Data}, 0);
    rst_n = 1'b1;
    step();

    // Test 1: single byte, then Rd_Ready while empty must do nothing
    write_byte(8'hA5, 1'b1);
    chk("t1_rd_valid", {31'd0, Rd_Valid}, 1);
    chk("t1_rd_data", {24'd0, Rd_Data}, 32'hA5);
    chk("t1_count", {27'd0, Count}, 1);
    step();
    chk("t1_hold_data", {24'd0, Rd_Data}, 32'hA5);
    drain(1);
    chk("t1_count_after", {27'd0, Count}, 0);
    chk("t1_valid_after", {31'd0, Rd_Valid}, 0);
    drain(2);
    chk("t1_empty_read", {27'd0, Count}, 0);

    // Test 2: fill with 0x00..0x0F and watch the flags
    for (int i = 0; i < 16; i++) begin
      write_byte(8'(i), 1'b1);
      chk("t2_count", {27'd0, Count}, 32'(i + 1));
      chk("t2_af", {31'd0, Almost_Full}, (i + 1 >= 12) ? 1 : 0);
      chk("t2_full", {31'd0, Full}, (i + 1 == 16) ? 1 : 0);
    end

    // Test 3: a write into the full FIFO is dropped and sets Overflow
    write_byte(8'h77, 1'b0);
    chk("t3_ovf", {31'd0, Overflow}, 1);
    chk("t3_count", {27'd0, Count}, 16);
    step();
    chk("t3_ovf_sticky", {31'd0, Overflow}, 1);
    Ovf_Clr = 1'b1;
    step();
    Ovf_Clr = 1'b0;
    chk("t3_ovf_clr", {31'd0, Overflow}, 0);

    // Drop and clear on the same edge: set wins
    Ovf_Clr = 1'b1;
    write_byte(8'h78, 1'b0);
    Ovf_Clr = 1'b0;
    chk("t3_set_wins", {31'd0, Overflow}, 1);
    Ovf_Clr = 1'b1;
    step();
    Ovf_Clr = 1'b0;

    // Test 4: full FIFO with simultaneous write and read
    Rd_Ready = 1'b1;
    write_byte(8'h55, 1'b1);
    Rd_Ready = 1'b0;
    chk("t4_count", {27'd0, Count}, 16);
    chk("t4_ovf", {31'd0, Overflow}, 0);
    chk("t4_full", {31'd0, Full}, 1);
    drain(16);
    chk("t4_drained", {27'd0, Count}, 0);
    chk("t4_af_low", {31'd0, Almost_Full}, 0);

    // Test 5: 40 bytes with Rd_Ready toggling every cycle; pointers wrap twice
    for (int c = 0; c < 80; c++) begin
      Rd_Ready = c[0];
      if (!c[0]) begin
        Wr_Data  = 8'((c / 2) * 7 + 3);
        Wr_Valid = 1'b1;
        exp_q.push_back(Wr_Data);
      end else begin
        Wr_Valid = 1'b0;
      end
      step();
    end
    Wr_Valid = 1'b0;
    Rd_Ready = 1'b0;
    chk("t5_count", {27'd0, Count}, 0);
    chk("t5_ovf", {31'd0, Overflow}, 0);
    chk("t5_queue_empty", 32'(exp_q.size()), 0);

    // Test 6: asynchronous reset with 5 bytes stored
    for (int i = 0; i < 5; i++) write_byte(8'hE0 + 8'(i), 1'b0);
    chk("t6_count_pre", {27'd0, Count}, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rd_valid", {31'd0, Rd_Valid}, 0);
    chk("t6_count", {27'd0, Count}, 0);
    chk("t6_full", {31'd0, Full}, 0);
    chk("t6_ovf", {31'd0, Overflow}, 0);
    step();
    rst_n = 1'b1;
    step();
    write_byte(8'h3C, 1'b1);
    chk("t6_rd_data", {24'd0, Rd_Data}, 32'h3C);
    chk("t6_count_post", {27'd0, Count}, 1);
    drain(1);
    chk("t6_count_end", {27'd0, Count}, 0);

    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
